// File: rtl/seq_nr_divider_if.sv
// -----------------------------------------------------------------------------
// seq_nr_divider_if
//   Request/result bundle for the iterative non-restoring divider.
//
//   Handshake: a request is accepted on a rising clock edge where start=1 and
//   the divider is idle (busy=0); X and Y are captured on that same edge, and
//   later changes to them have no effect. start is ignored while busy=1.
//   Completion is signalled by a one-cycle done pulse, in the same cycle that
//   Q, R and div_by_zero take their new values. A new request may be
//   presented during the done cycle and is accepted on the next edge.
//
//   Signals:
//     start        requester -> divider   request a division
//     X [N-1:0]    requester -> divider   dividend
//     Y [M-1:0]    requester -> divider   divisor
//     busy         divider -> requester   division in progress
//     done         divider -> requester   one-cycle completion pulse
//     Q [N-1:0]    divider -> requester   quotient (held between completions)
//     R [M-1:0]    divider -> requester   remainder (held between completions)
//     div_by_zero  divider -> requester   last completed request had Y == 0
// -----------------------------------------------------------------------------
interface seq_nr_divider_if #(
    parameter int N = 8,
    parameter int M = 4
);
    logic         start;
    logic [N-1:0] X;
    logic [M-1:0] Y;
    logic         busy;
    logic         done;
    logic [N-1:0] Q;
    logic [M-1:0] R;
    logic         div_by_zero;

    modport master (
        output start, X, Y,
        input  busy, done, Q, R, div_by_zero
    );

    modport slave (
        input  start, X, Y,
        output busy, done, Q, R, div_by_zero
    );
endinterface

// File: rtl/seq_nr_divider.sv
// -----------------------------------------------------------------------------
// seq_nr_divider
//   Iterative non-restoring unsigned divider: N-bit dividend X by M-bit
//   divisor Y, one quotient bit per clock through a single add/subtract
//   datapath, followed by one remainder-correction cycle. A zero divisor
//   completes on the accepting edge with div_by_zero=1, Q=all ones, R=0.
//
//   Ports:
//     clk        rising-edge clock
//     reset      asynchronous, active-high; aborts any division in flight
//     bus        seq_nr_divider_if slave (start/X/Y in, busy/done/Q/R/
//                div_by_zero out)
//     dbg_state  current FSM state (0=IDLE, 1=ITER, 2=CORRECT)
// -----------------------------------------------------------------------------
module seq_nr_divider #(
    parameter int N = 8,
    parameter int M = 4
) (
    input  logic                clk,
    input  logic                reset,
    seq_nr_divider_if.slave     bus,
    output logic [1:0]          dbg_state
);
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ITER    = 2'd1,
        CORRECT = 2'd2
    } state_t;

    state_t        state, state_n;
    logic [N-1:0]  a, a_n;        // dividend shifting out, quotient shifting in
    logic [M-1:0]  d, d_n;        // captured divisor
    logic [M:0]    p, p_n;        // partial remainder, two's complement
    logic [CW-1:0] cnt, cnt_n;    // quotient bits still to produce
    logic          busy_r, busy_n;
    logic          done_r, done_n;
    logic [N-1:0]  q_r, q_n;
    logic [M-1:0]  r_r, r_n;
    logic          dbz_r, dbz_n;

    logic [M:0]    d_ext;
    logic [M:0]    p_sh;
    logic [M:0]    p_step;
    logic [M:0]    p_fix;

    // The top bit lost by the shift is harmless: the true result of each step
    // lies in -D..D-1, which M+1 bits hold exactly, so modular arithmetic
    // lands on the right value.
    assign d_ext  = {1'b0, d};
    assign p_sh   = {p[M-1:0], a[N-1]};
    assign p_step = p[M] ? (p_sh + d_ext) : (p_sh - d_ext);
    // A negative final remainder is pulled back into 0..D-1.
    assign p_fix  = p[M] ? (p + d_ext) : p;

    always_comb begin
        state_n = state;
        a_n     = a;
        d_n     = d;
        p_n     = p;
        cnt_n   = cnt;
        busy_n  = busy_r;
        done_n  = 1'b0;
        q_n     = q_r;
        r_n     = r_r;
        dbz_n   = dbz_r;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    a_n   = bus.X;
                    d_n   = bus.Y;
                    p_n   = '0;
                    cnt_n = CW'(N);
                    if (bus.Y == '0) begin
                        done_n = 1'b1;
                        dbz_n  = 1'b1;
                        q_n    = '1;
                        r_n    = '0;
                        busy_n = 1'b0;
                    end else begin
                        busy_n  = 1'b1;
                        state_n = ITER;
                    end
                end
            end
            ITER: begin
                p_n   = p_step;
                // Quotient bit is 1 when the new partial remainder is >= 0.
                a_n   = {a[N-2:0], ~p_step[M]};
                cnt_n = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    state_n = CORRECT;
                end
            end
            CORRECT: begin
                p_n     = p_fix;
                q_n     = a;
                r_n     = p_fix[M-1:0];
                dbz_n   = 1'b0;
                done_n  = 1'b1;
                busy_n  = 1'b0;
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            a      <= '0;
            d      <= '0;
            p      <= '0;
            cnt    <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            q_r    <= '0;
            r_r    <= '0;
            dbz_r  <= 1'b0;
        end else begin
            state  <= state_n;
            a      <= a_n;
            d      <= d_n;
            p      <= p_n;
            cnt    <= cnt_n;
            busy_r <= busy_n;
            done_r <= done_n;
            q_r    <= q_n;
            r_r    <= r_n;
            dbz_r  <= dbz_n;
        end
    end

    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.Q           = q_r;
    assign bus.R           = r_r;
    assign bus.div_by_zero = dbz_r;
    assign dbg_state       = state;
endmodule

// File: doc/seq_nr_divider.md
Name: seq_nr_divider

Overview:
- Iterative, parametrised non-restoring unsigned divider: N-bit dividend X by M-bit divisor Y, giving quotient Q and remainder R.
- Uses one shared add/subtract datapath, clocked once per quotient bit, with a start/busy/done handshake.
- Adds a final remainder-correction cycle and divide-by-zero detection.
- Sits alongside the combinational array divider and replaces it where N grows beyond what an unrolled CAS array can afford.

Parameters:
- N, 8, dividend and quotient width (N >= 2)
- M, 4, divisor and remainder width (1 <= M <= N)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; clears all state and outputs
- start  input  1  request a division; sampled only while not busy
- X  input  N  dividend, captured on the accepting edge
- Y  input  M  divisor, captured on the accepting edge
- busy  output  1  high while a division is in progress
- done  output  1  one-cycle pulse when Q/R/div_by_zero are updated
- Q  output  N  quotient, held between completions
- R  output  M  remainder, held between completions
- div_by_zero  output  1  set with done when the captured Y == 0; held until next completion

Behaviour:
- Reset (async, active-high): busy=0, done=0, Q=0, R=0, div_by_zero=0, state=IDLE, iteration counter=0. Asserting reset mid-division aborts it; no done is produced.
- States: IDLE, ITER, CORRECT.
- IDLE, start=1 at edge e0:
  - Latch X into quotient shift register A and Y into D.
  - Clear partial remainder P, which is M+1 bits, two's complement.
  - Counter=N, busy=1.
  - If Y==0: go to IDLE directly. At e0 set done=1, div_by_zero=1, Q=all ones, R=0, busy=0. Latency is 1 cycle.
  - Otherwise go to ITER.
- ITER, one quotient bit per edge:
  - Form {P,A} shifted left by 1.
  - If the old P >= 0, P = shifted P - {0,D}; else P = shifted P + {0,D}.
  - New LSB of A = ~P[M] (sign of the new P).
  - Decrement the counter; after N iterations (edge eN) go to CORRECT.
- CORRECT, edge e(N+1):
  - If P[M]=1, P += {0,D}.
  - Q = A, R = P[M-1:0], div_by_zero=0, done=1, busy=0. Go to IDLE.
- Latency: done is high in the cycle after edge e(N+1), i.e. N+1 cycles after the accepting edge. busy is high from e0 until e(N+1).
- done:
  - Exactly one cycle wide.
  - Deasserts on the next edge unless that edge completes another division (only possible for a Y==0 request).
- start while busy=1 is ignored; the in-flight operation is unaffected.
- start in the done cycle (state IDLE) is accepted, which gives back-to-back operation with no dead cycle.
- X/Y changes after the accepting edge have no effect.
- Q/R/div_by_zero change only at completion and never expose intermediate values.
- Arithmetic:
  - P is M+1 bits, wide enough to hold -D..D-1 with no overflow.
  - Results satisfy X = Q*Y + R and 0 <= R < Y for every Y != 0.
  - When Y > X, the result is Q=0, R=X (X < Y fits in M bits).

Test Plan:
- Defaults N=8,M=4: X=200,Y=7, start one cycle -> done pulse exactly 9 cycles after the accepting edge, Q=28, R=4, div_by_zero=0; busy high for 9 cycles.
- X=255,Y=15 -> Q=17, R=0. X=5,Y=9 -> Q=0, R=5, so the correction step fires. X=0,Y=1 -> Q=0, R=0.
- X=77,Y=0 -> done in the cycle after the accepting edge, div_by_zero=1, Q=255, R=0, busy never observed high. The next valid divide (77/3) clears the flag and gives Q=25, R=2.
- During a 200/7 operation, pulse start with X=9,Y=3 at cycle 4 -> ignored, result stays 28/4. Assert start with 9/3 in the done cycle -> accepted, second done 9 cycles later with Q=3, R=0.
- Reset at cycle 5 of a division, asynchronously between edges -> busy, done, Q, R and div_by_zero go to 0 immediately, and no done follows. A subsequent 100/6 gives Q=16, R=4.
- Instance N=4,M=2: exhaustive X=0..15, Y=1..3 back-to-back -> every result matches X/Y and X%Y. Instance N=16,M=8: 1000 random vectors checked against the reference model.
